// File: rtl/dmem_pkg.sv
// dmem_pkg: line geometry and FSM encoding shared by the dmem_line_responder slice.
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: DEPTH x LINE_W line store, synchronous write and combinational read.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [LINE_W-1:0]        wdata_i,
    output logic [LINE_W-1:0]        rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency 256-bit line read/write responder for the dcache miss path.
// Build option DMEM_RANGE_CHECK_EN flags out-of-range line addresses on mem_err_o and suppresses them.
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_err_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              in_oor;
    logic              direct;
    logic              commit;
    logic              c_wr;
    logic              c_oor;
    logic [IW-1:0]     c_idx;
    logic [LINE_W-1:0] c_wdata;
    logic [LINE_W-1:0] arr_rdata;
    logic              unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
    assign in_oor      = |mem_addr_i[31:OFFSET_W+IW];
    assign unused_addr = ^mem_addr_i[OFFSET_W-1:0];
    assign mem_err_o   = (state_q == ACK) & oor_q;
`else
    assign in_oor      = 1'b0;
    assign unused_addr = ^{mem_addr_i[31:OFFSET_W+IW], mem_addr_i[OFFSET_W-1:0]};
    assign mem_err_o   = 1'b0;
`endif

    // With LATENCY==1 the IDLE edge is also the commit edge, so it works from the live inputs.
    assign direct  = (LATENCY == 1) && (state_q == IDLE);
    assign commit  = ((state_q == BUSY) && (cnt_q == CW'(1))) || (direct && mem_enable_i);
    assign c_wr    = direct ? mem_write_i : wr_q;
    assign c_oor   = direct ? in_oor : oor_q;
    assign c_idx   = direct ? mem_addr_i[OFFSET_W+IW-1:OFFSET_W] : idx_q;
    assign c_wdata = direct ? mem_data_i : wdata_q;

    dmem_line_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (commit & c_wr & ~c_oor),
        .idx_i  (c_idx),
        .wdata_i(c_wdata),
        .rdata_o(arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    wr_d    = mem_write_i;
                    idx_d   = mem_addr_i[OFFSET_W+IW-1:OFFSET_W];
                    wdata_d = mem_data_i;
                    oor_d   = in_oor;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ACK : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit && !c_wr) rdata_d = c_oor ? '0 : arr_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ack_o  = (state_q == ACK);
    assign mem_data_o = rdata_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb_dmem_line_responder: directed plus random line traffic checked against an associative-array memory model.
module tb_dmem_line_responder;

    localparam int DEPTH = 512;
    localparam int LAT   = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         wr  = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic         ack;
    logic [255:0] rdata;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [255:0] ref_mem [int];
    logic [255:0] last_rd = '0;

    dmem_line_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_enable_i(en),
        .mem_write_i (wr),
        .mem_addr_i  (addr),
        .mem_data_i  (wdata),
        .mem_ack_o   (ack),
        .mem_data_o  (rdata),
        .mem_err_o   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a >> 5) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_line(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after the ack.
    task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                       input bit keep, input bit glitch, output int ack_at);
        int  start;
        bit  seen;
        bit  oor;
        int  ln;
        oor   = m_oor(a);
        ln    = m_line(a);
        en    = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        start = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (glitch && i == 3) begin
                en    = 1'b0;
                wr    = ~w;
                addr  = $urandom;
                wdata = rnd256();
            end
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ack_seen", 256'(seen), 256'(1));
        ack_at = cyc;
        if (seen) begin
            chk("latency", 256'(cyc - start), 256'(LAT));
            if (w) begin
                if (!oor) ref_mem[ln] = d;
                chk("wr_keeps_rdata", rdata, last_rd);
            end else begin
                if (oor) last_rd = '0;
                else last_rd = ref_mem[ln];
                chk("rd_data", rdata, last_rd);
            end
            chk("err_at_ack", 256'(err), 256'(oor));
        end
        if (!keep) begin
            en    = 1'b0;
            wr    = $urandom_range(0, 1);
            addr  = $urandom;
            wdata = rnd256();
        end
        @(negedge clk);
        chk("ack_one_cycle", 256'(ack), 256'(0));
        chk("err_idle", 256'(err), 256'(0));
    endtask

    initial begin
        int a1, a2, at, n_ack;
        logic [31:0]  ra;
        logic         rw;
        logic [255:0] old2;

        repeat (3) @(negedge clk);
        chk("rst_ack", 256'(ack), 256'(0));
        chk("rst_data", rdata, '0);
        chk("rst_err", 256'(err), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // Test 1: line 3 survives a reset and reads back with exact latency
        req(1'b1, 32'h60, {32{8'hA5}}, 0, 0, at);
        rst = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("rst2_data", rdata, '0);
        rst = 1'b1;
        @(negedge clk);
        req(1'b0, 32'h60, '0, 0, 0, at);

        // Test 2: write line 7, read with offset bits set
        req(1'b1, 32'hE0, {16{16'h1234}}, 0, 0, at);
        req(1'b0, 32'hE4, '0, 0, 0, at);

        // Test 3: writeback then refill with enable held across the ack
        req(1'b1, 32'h2040, rnd256(), 0, 0, at);
        req(1'b1, 32'h40, rnd256(), 1, 0, a1);
        req(1'b0, 32'h2040, '0, 0, 0, a2);
        chk("b2b_gap", 256'(a2 - a1), 256'(LAT + 1));
        req(1'b0, 32'h40, '0, 0, 0, at);

        // Test 4: inputs disturbed mid-BUSY
        req(1'b1, 32'hA0, rnd256(), 0, 1, at);
        req(1'b0, 32'hA0, '0, 0, 0, at);
        req(1'b0, 32'hE0, '0, 0, 1, at);

        // Test 6: address above the array
        req(1'b1, 32'h0, rnd256(), 0, 0, at);
        req(1'b1, 32'h4000, rnd256(), 0, 0, at);
        req(1'b0, 32'h0, '0, 0, 0, at);
        req(1'b0, 32'h4000, '0, 0, 0, at);

        // Test 5: reset aborts a write to line 2
        old2 = rnd256();
        req(1'b1, 32'h40, old2, 0, 0, at);
        en    = 1'b1;
        wr    = 1'b1;
        addr  = 32'h45;
        wdata = ~old2;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("abort_ack", 256'(ack), 256'(0));
        chk("abort_data", rdata, '0);
        rst   = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        chk("abort_no_ack", 256'(n_ack), 256'(0));
        req(1'b0, 32'h40, '0, 0, 0, at);

        // Random traffic across a few lines, including wrapped upper bits
        for (int t = 0; t < 24; t++) begin
            ra = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
            rw = $urandom_range(0, 1);
            if (!rw && !m_oor(ra) && !ref_mem.exists(m_line(ra))) rw = 1'b1;
            req(rw, ra, rnd256(), (t < 23) && ($urandom_range(0, 1) == 1), 0, at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
